// File: rtl/icache_ctrl.sv
// Direct-mapped, one-word-per-line instruction cache with a single-outstanding
// refill controller sitting between the IF stage and the memory controller.
module icache_ctrl #(
  parameter int INDEX_W = 6,
  parameter int ADDR_W  = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        inv_i,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o,
  output logic        if_stallreq_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_inst_i,
  input  logic        mem_done_i,
  output logic [15:0] miss_cnt_o
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  typedef enum logic {
    S_IDLE,
    S_REFILL
  } state_e;

  state_e               state_q, state_d;
  logic                 mem_req_q, mem_req_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [15:0]          miss_cnt_q, miss_cnt_d;
  logic                 fill_we;

  logic [31:0]          data_q [LINES];
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [LINES-1:0]     valid_q;

  logic [INDEX_W-1:0]   lk_idx, fill_idx;
  logic [TAG_W-1:0]     lk_tag, fill_tag;
  logic                 lk_hit;

  // Byte offset is ignored; it is consumed here only to keep it visibly intentional.
  logic                 unused_addr_bits;
  assign unused_addr_bits = ^if_addr_i[1:0];

  // Lookup path: index decode, tag compare and data mux only, never mem_inst_i.
  assign lk_idx   = if_addr_i[INDEX_W+1:2];
  assign lk_tag   = if_addr_i[ADDR_W-1:INDEX_W+2];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign fill_idx = mem_addr_q[INDEX_W+1:2];
  assign fill_tag = mem_addr_q[ADDR_W-1:INDEX_W+2];

  always_comb begin
    // NOTE: every output and next-state signal gets a default first so no latch is inferred.
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    miss_cnt_d    = miss_cnt_q;
    fill_we       = 1'b0;
    if_valid_o    = 1'b0;
    if_inst_o     = 32'h0;
    if_stallreq_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (if_req_i) begin
          if (lk_hit) begin
            if_valid_o = 1'b1;
            if_inst_o  = data_q[lk_idx];
          end else begin
            if_stallreq_o = 1'b1;
            state_d       = S_REFILL;
            mem_req_d     = 1'b1;
            mem_addr_d    = {if_addr_i[31:2], 2'b00};
            if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
          end
        end
      end
      S_REFILL: begin
        // The in-flight fetch cannot be cancelled, so PC changes are ignored here.
        if_stallreq_o = 1'b1;
        if (mem_done_i) begin
          fill_we   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!rst) begin
      if_valid_o    = 1'b0;
      if_inst_o     = 32'h0;
      if_stallreq_o = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
      miss_cnt_q <= 16'h0;
      valid_q    <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      miss_cnt_q <= miss_cnt_d;
      // Invalidate wins over a same-cycle install: the line is written but stays invalid.
      if (inv_i)        valid_q           <= '0;
      else if (fill_we) valid_q[fill_idx] <= 1'b1;
    end
  end

  // NOTE: data and tag arrays have no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (rst && rdy && fill_we) begin
      data_q[fill_idx] <= mem_inst_i;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: a vector table for the main fetch flow plus
// hand-written sequences for invalidate/stall/reset races and counter saturation.
module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, if_req_i, inv_i, mem_done_i;
  logic [31:0] if_addr_i, mem_inst_i;
  logic [31:0] if_inst_o, mem_addr_o;
  logic        if_valid_o, if_stallreq_o, mem_req_o;
  logic [15:0] miss_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  icache_ctrl #(.INDEX_W(6), .ADDR_W(17)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .if_req_i      (if_req_i),
    .if_addr_i     (if_addr_i),
    .inv_i         (inv_i),
    .if_inst_o     (if_inst_o),
    .if_valid_o    (if_valid_o),
    .if_stallreq_o (if_stallreq_o),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_inst_i    (mem_inst_i),
    .mem_done_i    (mem_done_i),
    .miss_cnt_o    (miss_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        inv;
    logic        done;
    logic [31:0] minst;
    logic        e_valid;
    logic [31:0] e_inst;
    logic        e_stall;
    logic        e_mreq;
    logic [31:0] e_maddr;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [29];

  function automatic vec_t mk(logic req, logic [31:0] addr, logic inv, logic done,
                              logic [31:0] minst, logic e_valid, logic [31:0] e_inst,
                              logic e_stall, logic e_mreq, logic [31:0] e_maddr,
                              logic [15:0] e_cnt);
    vec_t v;
    v.req = req; v.addr = addr; v.inv = inv; v.done = done;
    v.minst = done ? minst : 32'hDEAD_BEEF;
    v.e_valid = e_valid; v.e_inst = e_inst; v.e_stall = e_stall;
    v.e_mreq = e_mreq; v.e_maddr = e_maddr; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h10;
    inv_i = 1'b0; mem_done_i = 1'b0; mem_inst_i = 32'h0;

    // Reset: combinational outputs forced low even with a request pending.
    #1;
    check("rst_valid", {31'h0, if_valid_o}, 32'h0);
    check("rst_stall", {31'h0, if_stallreq_o}, 32'h0);
    tick();
    tick();
    check("rst_mreq", {31'h0, mem_req_o}, 32'h0);
    check("rst_maddr", mem_addr_o, 32'h0);
    check("rst_cnt", {16'h0, miss_cnt_o}, 32'h0);
    rst = 1'b1;

    //                 req addr       inv done minst         | val inst          stl mrq maddr     cnt
    vecs[0]  = mk(1, 32'h010, 0, 0, 0,              0, 32'h0,          1, 0, 32'h000, 0);
    vecs[1]  = mk(1, 32'h010, 0, 0, 0,              0, 32'h0,          1, 1, 32'h010, 1);
    vecs[2]  = mk(1, 32'h010, 0, 0, 0,              0, 32'h0,          1, 1, 32'h010, 1);
    vecs[3]  = mk(1, 32'h010, 0, 0, 0,              0, 32'h0,          1, 1, 32'h010, 1);
    vecs[4]  = mk(1, 32'h010, 0, 0, 0,              0, 32'h0,          1, 1, 32'h010, 1);
    vecs[5]  = mk(1, 32'h010, 0, 1, 32'h0010_0093,  0, 32'h0,          1, 1, 32'h010, 1);
    vecs[6]  = mk(1, 32'h010, 0, 0, 0,              1, 32'h0010_0093,  0, 0, 32'h010, 1);
    vecs[7]  = mk(1, 32'h011, 0, 0, 0,              1, 32'h0010_0093,  0, 0, 32'h010, 1);
    vecs[8]  = mk(1, 32'h013, 0, 0, 0,              1, 32'h0010_0093,  0, 0, 32'h010, 1);
    vecs[9]  = mk(1, 32'h110, 0, 0, 0,              0, 32'h0,          1, 0, 32'h010, 1);
    vecs[10] = mk(1, 32'h110, 0, 1, 32'hAAAA_0001,  0, 32'h0,          1, 1, 32'h110, 2);
    vecs[11] = mk(1, 32'h110, 0, 0, 0,              1, 32'hAAAA_0001,  0, 0, 32'h110, 2);
    vecs[12] = mk(1, 32'h010, 0, 0, 0,              0, 32'h0,          1, 0, 32'h110, 2);
    vecs[13] = mk(1, 32'h010, 0, 1, 32'h0010_0093,  0, 32'h0,          1, 1, 32'h010, 3);
    vecs[14] = mk(1, 32'h010, 0, 0, 0,              1, 32'h0010_0093,  0, 0, 32'h010, 3);
    vecs[15] = mk(1, 32'h020, 0, 0, 0,              0, 32'h0,          1, 0, 32'h010, 3);
    vecs[16] = mk(1, 32'h040, 0, 0, 0,              0, 32'h0,          1, 1, 32'h020, 4);
    vecs[17] = mk(1, 32'h040, 0, 1, 32'h1234_5678,  0, 32'h0,          1, 1, 32'h020, 4);
    vecs[18] = mk(1, 32'h040, 0, 0, 0,              0, 32'h0,          1, 0, 32'h020, 4);
    vecs[19] = mk(1, 32'h040, 0, 1, 32'hCAFE_0040,  0, 32'h0,          1, 1, 32'h040, 5);
    vecs[20] = mk(1, 32'h040, 0, 0, 0,              1, 32'hCAFE_0040,  0, 0, 32'h040, 5);
    vecs[21] = mk(1, 32'h020, 0, 0, 0,              1, 32'h1234_5678,  0, 0, 32'h040, 5);
    vecs[22] = mk(0, 32'h020, 0, 0, 0,              0, 32'h0,          0, 0, 32'h040, 5);
    vecs[23] = mk(0, 32'h080, 0, 0, 0,              0, 32'h0,          0, 0, 32'h040, 5);
    vecs[24] = mk(0, 32'h080, 0, 0, 0,              0, 32'h0,          0, 0, 32'h040, 5);
    vecs[25] = mk(1, 32'h020, 1, 0, 0,              1, 32'h1234_5678,  0, 0, 32'h040, 5);
    vecs[26] = mk(1, 32'h020, 0, 0, 0,              0, 32'h0,          1, 0, 32'h040, 5);
    vecs[27] = mk(1, 32'h020, 0, 1, 32'h1234_5678,  0, 32'h0,          1, 1, 32'h020, 6);
    vecs[28] = mk(1, 32'h020, 0, 0, 0,              1, 32'h1234_5678,  0, 0, 32'h020, 6);

    for (int i = 0; i < 29; i++) begin
      if_req_i = vecs[i].req; if_addr_i = vecs[i].addr; inv_i = vecs[i].inv;
      mem_done_i = vecs[i].done; mem_inst_i = vecs[i].minst;
      #1;
      check($sformatf("v%0d_valid", i), {31'h0, if_valid_o}, {31'h0, vecs[i].e_valid});
      check($sformatf("v%0d_inst", i), if_inst_o, vecs[i].e_inst);
      check($sformatf("v%0d_stall", i), {31'h0, if_stallreq_o}, {31'h0, vecs[i].e_stall});
      check($sformatf("v%0d_mreq", i), {31'h0, mem_req_o}, {31'h0, vecs[i].e_mreq});
      check($sformatf("v%0d_maddr", i), mem_addr_o, vecs[i].e_maddr);
      check($sformatf("v%0d_cnt", i), {16'h0, miss_cnt_o}, {16'h0, vecs[i].e_cnt});
      tick();
    end
    inv_i = 1'b0; mem_done_i = 1'b0;

    // Invalidate in the same cycle as the refill install: line stays invalid.
    if_req_i = 1'b1; if_addr_i = 32'h30;
    #1;
    check("inv_miss_stall", {31'h0, if_stallreq_o}, 32'h1);
    tick();
    check("inv_refill_mreq", {31'h0, mem_req_o}, 32'h1);
    check("inv_refill_cnt", {16'h0, miss_cnt_o}, 32'd7);
    mem_done_i = 1'b1; mem_inst_i = 32'h3030_3030; inv_i = 1'b1;
    tick();
    mem_done_i = 1'b0; inv_i = 1'b0;
    #1;
    check("inv_idle_mreq", {31'h0, mem_req_o}, 32'h0);
    check("inv_remiss_stall", {31'h0, if_stallreq_o}, 32'h1);
    check("inv_remiss_valid", {31'h0, if_valid_o}, 32'h0);
    tick();
    check("inv_second_mreq", {31'h0, mem_req_o}, 32'h1);
    check("inv_second_cnt", {16'h0, miss_cnt_o}, 32'd8);

    // rdy low during REFILL: state frozen and a done pulse is ignored.
    rdy = 1'b0; mem_done_i = 1'b1; mem_inst_i = 32'hBAD0_BAD0; if_addr_i = 32'h10;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("frz%0d_mreq", c), {31'h0, mem_req_o}, 32'h1);
      check($sformatf("frz%0d_maddr", c), mem_addr_o, 32'h30);
      check($sformatf("frz%0d_stall", c), {31'h0, if_stallreq_o}, 32'h1);
      tick();
    end
    rdy = 1'b1; mem_done_i = 1'b0; if_addr_i = 32'h30;
    #1;
    check("frz_still_refill", {31'h0, mem_req_o}, 32'h1);
    check("frz_cnt", {16'h0, miss_cnt_o}, 32'd8);
    mem_done_i = 1'b1; mem_inst_i = 32'h3333_3333;
    tick();
    mem_done_i = 1'b0;
    #1;
    check("frz_fill_valid", {31'h0, if_valid_o}, 32'h1);
    check("frz_fill_inst", if_inst_o, 32'h3333_3333);

    // rdy low on an IDLE miss: no refill starts.
    rdy = 1'b0; if_addr_i = 32'h10;
    tick();
    rdy = 1'b1;
    #1;
    check("rdy_idle_mreq", {31'h0, mem_req_o}, 32'h0);
    check("rdy_idle_cnt", {16'h0, miss_cnt_o}, 32'd8);

    // Reset mid-REFILL abandons the fetch and invalidates every line.
    if_addr_i = 32'h50;
    tick();
    check("rr_refill_maddr", mem_addr_o, 32'h50);
    rst = 1'b0;
    #1;
    check("rr_comb_stall", {31'h0, if_stallreq_o}, 32'h0);
    check("rr_comb_inst", if_inst_o, 32'h0);
    tick();
    check("rr_mreq", {31'h0, mem_req_o}, 32'h0);
    check("rr_maddr", mem_addr_o, 32'h0);
    check("rr_cnt", {16'h0, miss_cnt_o}, 32'h0);
    rst = 1'b1; if_addr_i = 32'h30;
    #1;
    check("rr_line_invalid_stall", {31'h0, if_stallreq_o}, 32'h1);
    check("rr_line_invalid_valid", {31'h0, if_valid_o}, 32'h0);

    // Alternate two conflicting addresses so every fetch misses; counter saturates.
    for (int i = 0; i < 65540; i++) begin
      if_addr_i = i[0] ? 32'h110 : 32'h10;
      mem_done_i = 1'b0;
      tick();
      mem_done_i = 1'b1; mem_inst_i = i;
      tick();
      mem_done_i = 1'b0;
      if (i == 65533) check("sat_fffe", {16'h0, miss_cnt_o}, 32'h0000_FFFE);
      if (i == 65534) check("sat_ffff", {16'h0, miss_cnt_o}, 32'h0000_FFFF);
    end
    #1;
    check("sat_hold", {16'h0, miss_cnt_o}, 32'h0000_FFFF);
    check("sat_last_hit_inst", if_inst_o, 32'd65539);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
